audio_dsp_port: RTL and testbench
=================================

AUDIO_DSP_PORT -- requirements
Module: audio_dsp_port

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits per channel.
REQ-002 SHALL have parameter SYNC, default 2, number of synchroniser flops on each codec input; legal range 2..3.
REQ-003 SHALL have port clock50, input, 1, system clock (50 MHz); the block's only clock.
REQ-004 SHALL have port reset_n, input, 1, synchronous, active-low reset.
REQ-005 SHALL have port cfg_done, input, 1, high once the codec configuration has completed.
REQ-006 SHALL have ports aud_bclk, aud_adclrc, aud_daclrc and aud_adcdat, each input, 1, codec bit clock, ADC frame sync, DAC frame sync and ADC serial data.
REQ-007 SHALL have port aud_dacdat, output, 1, DAC serial data to the codec.
REQ-008 SHALL have ports adc_left and adc_right, each output, WIDTH, last captured ADC samples.
REQ-009 SHALL have port adc_valid, output, 1, one-clock50 pulse when a new ADC left/right pair is stored.
REQ-010 SHALL have ports dac_left and dac_right, each input, WIDTH, next DAC samples.
REQ-011 SHALL have port dac_ack, output, 1, one-clock50 pulse when dac_left/dac_right are latched for transmission.

Function
REQ-012 SHALL pass aud_bclk, aud_adclrc, aud_daclrc and aud_adcdat through SYNC-deep flop chains, with equal depth, before any use.
REQ-013 SHALL detect bclk rise and fall as single-cycle strobes from the last two synchronised bclk samples.
REQ-014 SHALL run separate ADC and DAC state machines, each with states WAIT_CFG, WAIT_SYNC, LEFT and RIGHT.
REQ-015 SHALL hold both machines in WAIT_CFG while cfg_done=0, and move to WAIT_SYNC on the clock after cfg_done is sampled 1.
REQ-016 SHALL, in WAIT_SYNC, move to LEFT on a bclk rise where the synchronised lrc equals 1, with bit counter = WIDTH-1 (codec DSP mode, MSB on the first bclk rise after the frame-sync rise).
REQ-017 ADC: SHALL, on each bclk rise in LEFT/RIGHT, shift the synchronised adcdat into the channel shift register, MSB first, and decrement the counter.
REQ-018 ADC: SHALL go LEFT->RIGHT when the counter reaches 0, and RIGHT->WAIT_SYNC when the counter reaches 0.
REQ-019 ADC: SHALL, on the clock after the last RIGHT bit, update adc_left/adc_right together and pulse adc_valid for exactly 1 cycle.
REQ-020 DAC: SHALL, on entry to LEFT, latch dac_left/dac_right into the transmit register, pulse dac_ack for 1 cycle, and drive the MSB on aud_dacdat.
REQ-021 DAC: SHALL update aud_dacdat only on bclk fall strobes, advancing one bit per fall, and use the bclk rise only for counting.
REQ-022 DAC: SHALL follow the LEFT->RIGHT->WAIT_SYNC sequence of REQ-018 and drive aud_dacdat=0 outside LEFT/RIGHT.
REQ-023 SHALL abandon a partial frame if an lrc=1 sample occurs at a bclk rise inside LEFT/RIGHT: leave adc_valid low, restart at LEFT with the counter reloaded.
REQ-024 SHALL keep adc_left/adc_right unchanged when a frame is abandoned.
REQ-025 SHALL return both machines to WAIT_CFG within 1 cycle if cfg_done falls mid-frame, with no adc_valid pulse.
REQ-026 SHALL treat bclk rise and lrc change in the same cycle as "lrc sampled at that rise" (post-sync values).
REQ-027 SHALL have aud_dacdat as a register output with no combinational path from inputs.

Reset
REQ-028 SHALL, while reset_n=0 at a clock50 rise, force both machines to WAIT_CFG.
REQ-029 SHALL, in reset, clear adc_left, adc_right, the shift registers, the counters and the sync flops to 0.
REQ-030 SHALL, in reset, drive adc_valid=0, dac_ack=0 and aud_dacdat=0.
REQ-031 SHALL treat reset asserted mid-frame as discarding the frame with no output pulses.

Configuration
REQ-032 SHALL, with LOOPBACK_EN defined, load the DAC transmit register from adc_left/adc_right instead of dac_left/dac_right; dac_ack still pulses.
REQ-033 SHALL, without LOOPBACK_EN, use dac_left/dac_right only and compile no loopback mux.

Verification
REQ-034 SHALL cover: cfg_done=0, codec frames running -> adc_valid never pulses, aud_dacdat stays 0.
REQ-035 SHALL cover: cfg_done=1, bclk=3.072 MHz, one frame adcdat = 0xA5C3 then 0x1234 -> adc_left=0xA5C3, adc_right=0x1234, one adc_valid pulse.
REQ-036 SHALL cover: dac_left=0x8001, dac_right=0x7FFE -> bits decoded at bclk rises equal 0x8001/0x7FFE MSB-first, one dac_ack per frame.
REQ-037 SHALL cover: lrc pulse after 7 left bits -> no adc_valid, next full frame captured correctly.
REQ-038 SHALL cover: reset_n=0 for 1 cycle mid-RIGHT -> outputs 0, no adc_valid, resync on next frame.
REQ-039 SHALL cover: LOOPBACK_EN defined, adc frame N = 0x0F0F/0xF0F0 -> frame N+1 DAC bits = 0x0F0F/0xF0F0.

Source files
------------

// File: rtl/audio_dsp_port.sv
// audio_dsp_port
//   Serial audio port for a codec running in DSP mode (frame-sync pulse,
//   MSB on the first bclk rise after the sync rise). The codec signals
//   are asynchronous to clock50. They are synchronised and then sampled
//   on bclk edge strobes.
//
//   Ports
//     clock50              system clock, the only clock in the block
//     reset_n              synchronous active-low reset
//     cfg_done             codec configuration complete; both machines idle while low
//     aud_bclk             codec bit clock (asynchronous input)
//     aud_adclrc           ADC frame sync (asynchronous input)
//     aud_daclrc           DAC frame sync (asynchronous input)
//     aud_adcdat           ADC serial data (asynchronous input)
//     aud_dacdat           DAC serial data (registered output)
//     adc_left/adc_right   last complete ADC sample pair
//     adc_valid            one-cycle pulse when adc_left/adc_right are updated
//     dac_left/dac_right   next DAC sample pair
//     dac_ack              one-cycle pulse when the DAC pair is latched
//
//   Build option
//     LOOPBACK_EN          when defined, the DAC transmits the last ADC pair
//                          instead of dac_left/dac_right
//
//   State table (same encoding for the ADC and DAC machines)
//     state     | meaning
//     WAIT_CFG  | codec not configured, port idle
//     WAIT_SYNC | waiting for a bclk rise with the frame sync high
//     LEFT      | left channel bits, counter = bits still to go - 1
//     RIGHT     | right channel bits, counter = bits still to go - 1
module audio_dsp_port #(
   parameter int WIDTH = 16,
   parameter int SYNC  = 2
) (
   input  logic             clock50,
   input  logic             reset_n,
   input  logic             cfg_done,
   input  logic             aud_bclk,
   input  logic             aud_adclrc,
   input  logic             aud_daclrc,
   input  logic             aud_adcdat,
   output logic             aud_dacdat,
   output logic [WIDTH-1:0] adc_left,
   output logic [WIDTH-1:0] adc_right,
   output logic             adc_valid,
   input  logic [WIDTH-1:0] dac_left,
   input  logic [WIDTH-1:0] dac_right,
   output logic             dac_ack
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {WAIT_CFG, WAIT_SYNC, LEFT, RIGHT} state_t;

   // All four chains have the same depth, so lrc/adcdat line up with the bclk strobe.
   logic [SYNC-1:0] bclk_sr, adclrc_sr, daclrc_sr, adcdat_sr;
   logic            bclk_d;

   always_ff @(posedge clock50) begin
      if (!reset_n) begin
         bclk_sr   <= '0;
         adclrc_sr <= '0;
         daclrc_sr <= '0;
         adcdat_sr <= '0;
         bclk_d    <= 1'b0;
      end else begin
         bclk_sr   <= {bclk_sr[SYNC-2:0], aud_bclk};
         adclrc_sr <= {adclrc_sr[SYNC-2:0], aud_adclrc};
         daclrc_sr <= {daclrc_sr[SYNC-2:0], aud_daclrc};
         adcdat_sr <= {adcdat_sr[SYNC-2:0], aud_adcdat};
         bclk_d    <= bclk_sr[SYNC-1];
      end
   end

   logic bclk_s, adclrc_s, daclrc_s, adcdat_s;
   logic bclk_rise, bclk_fall;

   assign bclk_s    = bclk_sr[SYNC-1];
   assign adclrc_s  = adclrc_sr[SYNC-1];
   assign daclrc_s  = daclrc_sr[SYNC-1];
   assign adcdat_s  = adcdat_sr[SYNC-1];
   assign bclk_rise = bclk_s & ~bclk_d;
   assign bclk_fall = ~bclk_s & bclk_d;

   // ---------------- ADC receive ----------------
   state_t           adc_state;
   logic [CW-1:0]    adc_cnt;
   logic [WIDTH-1:0] adc_sh_l, adc_sh_r;
   logic             adc_done;

   always_ff @(posedge clock50) begin
      if (!reset_n) begin
         adc_state <= WAIT_CFG;
         adc_cnt   <= '0;
         adc_sh_l  <= '0;
         adc_sh_r  <= '0;
         adc_left  <= '0;
         adc_right <= '0;
         adc_valid <= 1'b0;
         adc_done  <= 1'b0;
      end else begin
         adc_valid <= 1'b0;
         adc_done  <= 1'b0;
         // Publish one cycle after the last right bit so both shift registers are final.
         if (adc_done && cfg_done) begin
            adc_left  <= adc_sh_l;
            adc_right <= adc_sh_r;
            adc_valid <= 1'b1;
         end
         if (!cfg_done) begin
            adc_state <= WAIT_CFG;
         end else begin
            case (adc_state)
               WAIT_CFG: adc_state <= WAIT_SYNC;
               WAIT_SYNC: begin
                  if (bclk_rise && adclrc_s) begin
                     adc_state <= LEFT;
                     adc_cnt   <= CNT_TOP;
                  end
               end
               LEFT, RIGHT: begin
                  if (bclk_rise) begin
                     if (adclrc_s) begin
                        // Early frame sync: drop the partial frame and restart.
                        adc_state <= LEFT;
                        adc_cnt   <= CNT_TOP;
                     end else begin
                        if (adc_state == LEFT)
                           adc_sh_l <= {adc_sh_l[WIDTH-2:0], adcdat_s};
                        else
                           adc_sh_r <= {adc_sh_r[WIDTH-2:0], adcdat_s};
                        if (adc_cnt == '0) begin
                           adc_cnt <= CNT_TOP;
                           if (adc_state == LEFT) begin
                              adc_state <= RIGHT;
                           end else begin
                              adc_state <= WAIT_SYNC;
                              adc_done  <= 1'b1;
                           end
                        end else begin
                           adc_cnt <= adc_cnt - CNT_ONE;
                        end
                     end
                  end
               end
               default: adc_state <= WAIT_CFG;
            endcase
         end
      end
   end

   // ---------------- DAC transmit ----------------
   logic [WIDTH-1:0] src_l, src_r;

`ifdef LOOPBACK_EN
   logic unused_dac;
   assign unused_dac = ^{dac_left, dac_right};
   assign src_l = adc_left;
   assign src_r = adc_right;
`else
   assign src_l = dac_left;
   assign src_r = dac_right;
`endif

   state_t           dac_state;
   logic [CW-1:0]    dac_cnt;
   logic [WIDTH-1:0] tx_l, tx_r;

   always_ff @(posedge clock50) begin
      if (!reset_n) begin
         dac_state  <= WAIT_CFG;
         dac_cnt    <= '0;
         tx_l       <= '0;
         tx_r       <= '0;
         aud_dacdat <= 1'b0;
         dac_ack    <= 1'b0;
      end else begin
         dac_ack <= 1'b0;
         if (!cfg_done) begin
            dac_state  <= WAIT_CFG;
            aud_dacdat <= 1'b0;
         end else if ((dac_state != WAIT_CFG) && bclk_rise && daclrc_s) begin
            // Frame start, or restart of an abandoned frame: latch and present the MSB.
            dac_state  <= LEFT;
            dac_cnt    <= CNT_TOP;
            tx_l       <= src_l;
            tx_r       <= src_r;
            aud_dacdat <= src_l[WIDTH-1];
            dac_ack    <= 1'b1;
         end else begin
            case (dac_state)
               WAIT_CFG: begin
                  dac_state  <= WAIT_SYNC;
                  aud_dacdat <= 1'b0;
               end
               WAIT_SYNC: aud_dacdat <= 1'b0;
               LEFT, RIGHT: begin
                  // Rises only count bits the codec has taken; the line moves on falls,
                  // so the first fall after the sync rise re-drives the MSB.
                  if (bclk_rise) begin
                     if (dac_cnt == '0) begin
                        dac_cnt <= CNT_TOP;
                        if (dac_state == LEFT) begin
                           dac_state <= RIGHT;
                        end else begin
                           dac_state  <= WAIT_SYNC;
                           aud_dacdat <= 1'b0;
                        end
                     end else begin
                        dac_cnt <= dac_cnt - CNT_ONE;
                     end
                  end else if (bclk_fall) begin
                     aud_dacdat <= (dac_state == LEFT) ? tx_l[dac_cnt] : tx_r[dac_cnt];
                  end
               end
               default: dac_state <= WAIT_CFG;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_audio_dsp_port.sv
// tb_audio_dsp_port
//   Directed bench for audio_dsp_port. The codec side is modelled as a DSP-mode
//   master: frame sync and ADC data change on bclk falls, and the DAC line is
//   sampled on bclk rises. The bench is built with or without LOOPBACK_EN to
//   match the DUT build.
module tb_audio_dsp_port;

   logic        clock50    = 1'b0;
   logic        reset_n    = 1'b0;
   logic        cfg_done   = 1'b0;
   logic        aud_bclk   = 1'b0;
   logic        aud_adclrc = 1'b0;
   logic        aud_daclrc = 1'b0;
   logic        aud_adcdat = 1'b0;
   logic        aud_dacdat;
   logic [15:0] adc_left, adc_right;
   logic        adc_valid;
   logic [15:0] dac_left  = 16'h0000;
   logic [15:0] dac_right = 16'h0000;
   logic        dac_ack;

   int tests = 0;
   int fails = 0;
   int valid_cnt = 0;
   int ack_cnt = 0;
   int dac_high_cnt = 0;

   logic [15:0] cap_l, cap_r;
   logic [15:0] model_adc_l = 16'h0000;
   logic [15:0] model_adc_r = 16'h0000;

   audio_dsp_port #(.WIDTH(16), .SYNC(2)) dut (
      .clock50   (clock50),
      .reset_n   (reset_n),
      .cfg_done  (cfg_done),
      .aud_bclk  (aud_bclk),
      .aud_adclrc(aud_adclrc),
      .aud_daclrc(aud_daclrc),
      .aud_adcdat(aud_adcdat),
      .aud_dacdat(aud_dacdat),
      .adc_left  (adc_left),
      .adc_right (adc_right),
      .adc_valid (adc_valid),
      .dac_left  (dac_left),
      .dac_right (dac_right),
      .dac_ack   (dac_ack)
   );

   always #10 clock50 = ~clock50;

   // Counted on the falling edge, so a pulse held two cycles counts twice.
   always @(negedge clock50) begin
      if (adc_valid === 1'b1) valid_cnt <= valid_cnt + 1;
      if (dac_ack === 1'b1) ack_cnt <= ack_cnt + 1;
      if (aud_dacdat !== 1'b0) dac_high_cnt <= dac_high_cnt + 1;
   end

   // Expected DAC word for a frame that starts now.
   function automatic logic [15:0] exp_tx_l();
`ifdef LOOPBACK_EN
      return model_adc_l;
`else
      return dac_left;
`endif
   endfunction

   function automatic logic [15:0] exp_tx_r();
`ifdef LOOPBACK_EN
      return model_adc_r;
`else
      return dac_right;
`endif
   endfunction

   // One bclk period: low phase 8 clocks (codec changes lrc/data), high phase 8 clocks.
   task automatic bclk_bit(input logic lrc, input logic d, output logic dac_bit);
      @(negedge clock50);
      aud_bclk   = 1'b0;
      aud_adclrc = lrc;
      aud_daclrc = lrc;
      aud_adcdat = d;
      repeat (8) @(negedge clock50);
      aud_bclk = 1'b1;
      dac_bit  = aud_dacdat;
      repeat (7) @(negedge clock50);
   endtask

   task automatic idle(input int n);
      logic b;
      for (int i = 0; i < n; i++) bclk_bit(1'b0, 1'b0, b);
   endtask

   task automatic send_bits(input logic [15:0] l, input logic [15:0] r);
      logic b;
      for (int i = 15; i >= 0; i--) begin
         bclk_bit(1'b0, l[i], b);
         cap_l[i] = b;
      end
      for (int i = 15; i >= 0; i--) begin
         bclk_bit(1'b0, r[i], b);
         cap_r[i] = b;
      end
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
      logic b;
      bclk_bit(1'b1, 1'b0, b);
      send_bits(l, r);
      idle(3);
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clock50);
      tests++; if (adc_left !== 16'h0000) begin fails++; $display("FAIL reset_adc_left: got %h want 0000", adc_left); end
      tests++; if (adc_right !== 16'h0000) begin fails++; $display("FAIL reset_adc_right: got %h want 0000", adc_right); end
      tests++; if (adc_valid !== 1'b0) begin fails++; $display("FAIL reset_adc_valid: got %b want 0", adc_valid); end
      tests++; if (dac_ack !== 1'b0) begin fails++; $display("FAIL reset_dac_ack: got %b want 0", dac_ack); end
      tests++; if (aud_dacdat !== 1'b0) begin fails++; $display("FAIL reset_dacdat: got %b want 0", aud_dacdat); end
      reset_n = 1'b1;
      repeat (2) @(negedge clock50);
   endtask

   task automatic test_no_cfg();
      int v0, a0, h0;
      cfg_done  = 1'b0;
      dac_left  = 16'hFFFF;
      dac_right = 16'hFFFF;
      v0 = valid_cnt; a0 = ack_cnt; h0 = dac_high_cnt;
      send_frame(16'h1234, 16'h5678);
      send_frame(16'h9ABC, 16'hDEF0);
      tests++; if (valid_cnt - v0 != 0) begin fails++; $display("FAIL nocfg_valid: got %0d pulses want 0", valid_cnt - v0); end
      tests++; if (ack_cnt - a0 != 0) begin fails++; $display("FAIL nocfg_ack: got %0d pulses want 0", ack_cnt - a0); end
      tests++; if (dac_high_cnt - h0 != 0) begin fails++; $display("FAIL nocfg_dacdat: got %0d high cycles want 0", dac_high_cnt - h0); end
      tests++; if (adc_left !== 16'h0000) begin fails++; $display("FAIL nocfg_adc_left: got %h want 0000", adc_left); end
   endtask

   task automatic test_adc_frame();
      int v0, a0;
      logic [15:0] el, er;
      cfg_done = 1'b1;
      repeat (4) @(negedge clock50);
      dac_left  = 16'h8001;
      dac_right = 16'h7FFE;
      el = exp_tx_l(); er = exp_tx_r();
      v0 = valid_cnt; a0 = ack_cnt;
      send_frame(16'hA5C3, 16'h1234);
      model_adc_l = 16'hA5C3; model_adc_r = 16'h1234;
      tests++; if (adc_left !== 16'hA5C3) begin fails++; $display("FAIL frame_adc_left: got %h want a5c3", adc_left); end
      tests++; if (adc_right !== 16'h1234) begin fails++; $display("FAIL frame_adc_right: got %h want 1234", adc_right); end
      tests++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL frame_valid: got %0d pulses want 1", valid_cnt - v0); end
      tests++; if (ack_cnt - a0 != 1) begin fails++; $display("FAIL frame_ack: got %0d pulses want 1", ack_cnt - a0); end
      tests++; if (cap_l !== el) begin fails++; $display("FAIL frame_dac_left: got %h want %h", cap_l, el); end
      tests++; if (cap_r !== er) begin fails++; $display("FAIL frame_dac_right: got %h want %h", cap_r, er); end
   endtask

   task automatic test_back_to_back();
      int v0, a0;
      logic [15:0] el, er;
      dac_left  = 16'h1111;
      dac_right = 16'h2222;
      el = exp_tx_l(); er = exp_tx_r();
      send_frame(16'h0F0F, 16'hF0F0);
      model_adc_l = 16'h0F0F; model_adc_r = 16'hF0F0;
      tests++; if (cap_l !== el) begin fails++; $display("FAIL b2b_n_dac_left: got %h want %h", cap_l, el); end
      tests++; if (adc_left !== 16'h0F0F) begin fails++; $display("FAIL b2b_n_adc_left: got %h want 0f0f", adc_left); end
      dac_left  = 16'h3333;
      dac_right = 16'h4444;
      el = exp_tx_l(); er = exp_tx_r();
      v0 = valid_cnt; a0 = ack_cnt;
      send_frame(16'h0000, 16'hFFFF);
      model_adc_l = 16'h0000; model_adc_r = 16'hFFFF;
      tests++; if (cap_l !== el) begin fails++; $display("FAIL b2b_n1_dac_left: got %h want %h", cap_l, el); end
      tests++; if (cap_r !== er) begin fails++; $display("FAIL b2b_n1_dac_right: got %h want %h", cap_r, er); end
      tests++; if (adc_left !== 16'h0000) begin fails++; $display("FAIL b2b_n1_adc_left: got %h want 0000", adc_left); end
      tests++; if (adc_right !== 16'hFFFF) begin fails++; $display("FAIL b2b_n1_adc_right: got %h want ffff", adc_right); end
      tests++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL b2b_valid: got %0d pulses want 1", valid_cnt - v0); end
      tests++; if (ack_cnt - a0 != 1) begin fails++; $display("FAIL b2b_ack: got %0d pulses want 1", ack_cnt - a0); end
   endtask

   task automatic test_abort();
      int v0, a0;
      logic b;
      logic [15:0] el, er;
      dac_left  = 16'h5555;
      dac_right = 16'hAAAA;
      v0 = valid_cnt; a0 = ack_cnt;
      bclk_bit(1'b1, 1'b0, b);
      for (int i = 0; i < 7; i++) bclk_bit(1'b0, 1'b1, b);
      bclk_bit(1'b1, 1'b0, b);
      repeat (4) @(negedge clock50);
      tests++; if (valid_cnt - v0 != 0) begin fails++; $display("FAIL abort_no_valid: got %0d pulses want 0", valid_cnt - v0); end
      tests++; if (adc_left !== 16'h0000) begin fails++; $display("FAIL abort_adc_left_kept: got %h want 0000", adc_left); end
      tests++; if (adc_right !== 16'hFFFF) begin fails++; $display("FAIL abort_adc_right_kept: got %h want ffff", adc_right); end
      el = exp_tx_l(); er = exp_tx_r();
      send_bits(16'h1357, 16'h2468);
      idle(3);
      model_adc_l = 16'h1357; model_adc_r = 16'h2468;
      tests++; if (adc_left !== 16'h1357) begin fails++; $display("FAIL abort_next_left: got %h want 1357", adc_left); end
      tests++; if (adc_right !== 16'h2468) begin fails++; $display("FAIL abort_next_right: got %h want 2468", adc_right); end
      tests++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL abort_valid: got %0d pulses want 1", valid_cnt - v0); end
      tests++; if (ack_cnt - a0 != 2) begin fails++; $display("FAIL abort_ack: got %0d pulses want 2", ack_cnt - a0); end
      tests++; if (cap_l !== el) begin fails++; $display("FAIL abort_dac_left: got %h want %h", cap_l, el); end
   endtask

   task automatic test_cfg_drop();
      int v0, h0;
      logic b;
      logic [15:0] el;
      dac_left  = 16'hFFFF;
      dac_right = 16'hFFFF;
      el = exp_tx_l();
      v0 = valid_cnt;
      bclk_bit(1'b1, 1'b0, b);
      tests++; if (aud_dacdat !== el[15]) begin fails++; $display("FAIL cfgdrop_msb: got %b want %b", aud_dacdat, el[15]); end
      @(negedge clock50);
      cfg_done = 1'b0;
      @(negedge clock50);
      tests++; if (aud_dacdat !== 1'b0) begin fails++; $display("FAIL cfgdrop_dacdat: got %b want 0", aud_dacdat); end
      h0 = dac_high_cnt;
      send_bits(16'hAAAA, 16'h5555);
      idle(2);
      tests++; if (valid_cnt - v0 != 0) begin fails++; $display("FAIL cfgdrop_no_valid: got %0d pulses want 0", valid_cnt - v0); end
      tests++; if (dac_high_cnt - h0 != 0) begin fails++; $display("FAIL cfgdrop_dacdat_idle: got %0d high cycles want 0", dac_high_cnt - h0); end
      tests++; if (adc_left !== 16'h1357) begin fails++; $display("FAIL cfgdrop_adc_kept: got %h want 1357", adc_left); end
      cfg_done = 1'b1;
      repeat (4) @(negedge clock50);
      v0 = valid_cnt;
      send_frame(16'h6C6C, 16'h9393);
      model_adc_l = 16'h6C6C; model_adc_r = 16'h9393;
      tests++; if (adc_left !== 16'h6C6C) begin fails++; $display("FAIL cfgdrop_next_left: got %h want 6c6c", adc_left); end
      tests++; if (adc_right !== 16'h9393) begin fails++; $display("FAIL cfgdrop_next_right: got %h want 9393", adc_right); end
      tests++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL cfgdrop_valid: got %0d pulses want 1", valid_cnt - v0); end
   endtask

   task automatic test_reset_mid_right();
      int v0, a0;
      logic b;
      logic [15:0] el, er;
      dac_left  = 16'hC3C3;
      dac_right = 16'h3C3C;
      v0 = valid_cnt;
      bclk_bit(1'b1, 1'b0, b);
      for (int i = 0; i < 16; i++) bclk_bit(1'b0, 1'b1, b);
      for (int i = 0; i < 5; i++) bclk_bit(1'b0, 1'b1, b);
      @(negedge clock50);
      reset_n = 1'b0;
      @(negedge clock50);
      reset_n = 1'b1;
      tests++; if (adc_left !== 16'h0000) begin fails++; $display("FAIL midrst_adc_left: got %h want 0000", adc_left); end
      tests++; if (adc_right !== 16'h0000) begin fails++; $display("FAIL midrst_adc_right: got %h want 0000", adc_right); end
      tests++; if (aud_dacdat !== 1'b0) begin fails++; $display("FAIL midrst_dacdat: got %b want 0", aud_dacdat); end
      model_adc_l = 16'h0000; model_adc_r = 16'h0000;
      for (int i = 0; i < 11; i++) bclk_bit(1'b0, 1'b1, b);
      idle(2);
      tests++; if (valid_cnt - v0 != 0) begin fails++; $display("FAIL midrst_no_valid: got %0d pulses want 0", valid_cnt - v0); end
      el = exp_tx_l(); er = exp_tx_r();
      v0 = valid_cnt; a0 = ack_cnt;
      send_frame(16'hBEEF, 16'hCAFE);
      model_adc_l = 16'hBEEF; model_adc_r = 16'hCAFE;
      tests++; if (adc_left !== 16'hBEEF) begin fails++; $display("FAIL midrst_resync_left: got %h want beef", adc_left); end
      tests++; if (adc_right !== 16'hCAFE) begin fails++; $display("FAIL midrst_resync_right: got %h want cafe", adc_right); end
      tests++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL midrst_valid: got %0d pulses want 1", valid_cnt - v0); end
      tests++; if (ack_cnt - a0 != 1) begin fails++; $display("FAIL midrst_ack: got %0d pulses want 1", ack_cnt - a0); end
      tests++; if (cap_l !== el) begin fails++; $display("FAIL midrst_dac_left: got %h want %h", cap_l, el); end
      tests++; if (cap_r !== er) begin fails++; $display("FAIL midrst_dac_right: got %h want %h", cap_r, er); end
   endtask

   initial begin
      test_reset();
      test_no_cfg();
      test_adc_frame();
      test_back_to_back();
      test_abort();
      test_cfg_drop();
      test_reset_mid_right();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
